// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the in-order writeback (primary, never stalled) and the
// mul/div unit (secondary, valid/ready, FIFO-buffered) onto the single
// register-file write port.
//
// Optional feature: define WB_BYPASS_EN to let a secondary request go straight
// to the output register when the FIFO is empty and the primary is idle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   p_we, p_rw, p_w          primary write request (no backpressure)
//   s_valid, s_rw, s_w       secondary write request
//   s_ready                  secondary accept (from registered occupancy)
//   WE, rW, W                registered regfile write port
//   pend                     mask of registers with a live queued write
//   s_count                  FIFO occupancy, 0..DEPTH
module wb_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p_we,
    input  logic [4:0]               p_rw,
    input  logic [31:0]              p_w,
    input  logic                     s_valid,
    input  logic [4:0]               s_rw,
    input  logic [31:0]              s_w,
    output logic                     s_ready,
    output logic                     WE,
    output logic [4:0]               rW,
    output logic [31:0]              W,
    output logic [31:0]              pend,
    output logic [$clog2(DEPTH):0]   s_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    typedef struct packed {
        logic        live;
        logic [4:0]  rw;
        logic [31:0] w;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    entry_t          fifo_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            we_q, we_d;
    logic [4:0]      rw_q, rw_d;
    logic [31:0]     w_q, w_d;

    logic            p_act;
    logic            s_push;
    logic            push;
    logic            pop;
    logic [31:0]     pend_c;

    // Writes to r0 are dropped at the input; the handshake still completes.
    assign s_ready = (count_q < CW'(DEPTH));
    assign p_act   = p_we && (p_rw != 5'd0);
    assign s_push  = s_valid && s_ready && (s_rw != 5'd0);

    // Output selection, ordering kill and FIFO bookkeeping.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        we_d     = 1'b0;
        rw_d     = rw_q;
        w_d      = w_q;
        pop      = 1'b0;
        push     = s_push;

        // A primary write is newer than any queued write to the same register.
        for (int i = 0; i < DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
            if (p_act && (fifo_q[i].rw == p_rw)) begin
                fifo_d[i].live = 1'b0;
            end
        end

        if (p_act) begin
            we_d = 1'b1;
            rw_d = p_rw;
            w_d  = p_w;
        end else if (count_q != CW'(0)) begin
            // Killed entries still pop, just without a write.
            pop                  = 1'b1;
            we_d                 = fifo_q[rd_ptr_q].live;
            rw_d                 = fifo_q[rd_ptr_q].rw;
            w_d                  = fifo_q[rd_ptr_q].w;
            fifo_d[rd_ptr_q].live = 1'b0;
            rd_ptr_d             = rd_ptr_q + PW'(1);
        end else if (BYPASS_EN && s_push) begin
            we_d = 1'b1;
            rw_d = s_rw;
            w_d  = s_w;
            push = 1'b0;
        end

        // Enqueued after the kill so a same-cycle secondary write stays live.
        if (push) begin
            fifo_d[wr_ptr_q].live = 1'b1;
            fifo_d[wr_ptr_q].rw   = s_rw;
            fifo_d[wr_ptr_q].w    = s_w;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Pending mask over live entries; popped slots have live cleared.
    always_comb begin
        pend_c = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_q[i].live) begin
                pend_c[fifo_q[i].rw] = 1'b1;
            end
        end
    end

    assign pend    = pend_c & ~32'd1;
    assign WE      = we_q;
    assign rW      = rw_q;
    assign W       = w_q;
    assign s_count = count_q;

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            rw_q     <= 5'd0;
            w_q      <= 32'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            rw_q     <= rw_d;
            w_q      <= w_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed vectors, a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst;
    logic                   p_we;
    logic [4:0]             p_rw;
    logic [31:0]            p_w;
    logic                   s_valid;
    logic [4:0]             s_rw;
    logic [31:0]            s_w;
    logic                   s_ready;
    logic                   WE;
    logic [4:0]             rW;
    logic [31:0]            W;
    logic [31:0]            pend;
    logic [$clog2(DEPTH):0] s_count;

    int total = 0;
    int bad   = 0;
    int r7_stale = 0;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .p_we    (p_we),
        .p_rw    (p_rw),
        .p_w     (p_w),
        .s_valid (s_valid),
        .s_rw    (s_rw),
        .s_w     (s_w),
        .s_ready (s_ready),
        .WE      (WE),
        .rW      (rW),
        .W       (W),
        .pend    (pend),
        .s_count (s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of pending writes plus the output register.
    typedef struct {
        bit        live;
        bit [4:0]  rw;
        bit [31:0] w;
    } ent_t;

    ent_t      mq[$];
    bit        m_we = 1'b0;
    bit [4:0]  m_rw = 5'd0;
    bit [31:0] m_w  = 32'd0;
    bit        m_pact;
    bit        m_enq;
    bit        m_ready;
    ent_t      m_e;

    function automatic logic [31:0] model_pend();
        logic [31:0] m;
        m = 32'd0;
        foreach (mq[k]) if (mq[k].live) m = m | (32'd1 << mq[k].rw);
        return m;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_we = 1'b0;
            m_rw = 5'd0;
            m_w  = 32'd0;
        end else begin
            m_ready = (mq.size() < DEPTH);
            m_pact  = p_we && (p_rw != 5'd0);
            m_enq   = s_valid && m_ready && (s_rw != 5'd0);
            if (m_pact) begin
                for (int k = 0; k < mq.size(); k++) begin
                    if (mq[k].rw == p_rw) begin
                        m_e = mq[k];
                        m_e.live = 1'b0;
                        mq[k] = m_e;
                    end
                end
                m_we = 1'b1;
                m_rw = p_rw;
                m_w  = p_w;
            end else if (mq.size() > 0) begin
                m_e  = mq.pop_front();
                m_we = m_e.live;
                m_rw = m_e.rw;
                m_w  = m_e.w;
            end
`ifdef WB_BYPASS_EN
            else if (m_enq) begin
                m_we  = 1'b1;
                m_rw  = s_rw;
                m_w   = s_w;
                m_enq = 1'b0;
            end
`endif
            else begin
                m_we = 1'b0;
            end
            if (m_enq) begin
                m_e.live = 1'b1;
                m_e.rw   = s_rw;
                m_e.w    = s_w;
                mq.push_back(m_e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("WE",      32'(WE),      32'(m_we));
        check("rW",      32'(rW),      32'(m_rw));
        check("W",       W,            m_w);
        check("s_count", 32'(s_count), 32'(mq.size()));
        check("pend",    pend,         model_pend());
        if (!rst) check("s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
        if (WE === 1'b1 && rW == 5'd7 && W == 32'h11) r7_stale++;
    end

    // One clock: inputs applied now, returns at the following negedge.
    task automatic cyc(input logic pwe, input logic [4:0] prw, input logic [31:0] pw,
                       input logic sv, input logic [4:0] srw, input logic [31:0] sw);
        p_we    = pwe;
        p_rw    = prw;
        p_w     = pw;
        s_valid = sv;
        s_rw    = srw;
        s_w     = sw;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        p_we = 1'b0; p_rw = 5'd0; p_w = 32'd0;
        s_valid = 1'b0; s_rw = 5'd0; s_w = 32'd0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_WE", 32'(WE), 32'd0);
        check("rst_count", 32'(s_count), 32'd0);
        check("rst_pend", pend, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_ready", 32'(s_ready), 32'd1);
        @(negedge clk);

        // Primary only, then a primary r0 write that must be dropped.
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check("prim_WE", 32'(WE), 32'd1);
        check("prim_rW", 32'(rW), 32'd5);
        check("prim_W", W, 32'hDEADBEEF);
        cyc(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
        check("prim_r0_WE", 32'(WE), 32'd0);
        check("prim_r0_hold_rW", 32'(rW), 32'd5);

        // Fill while primary is busy, try one more when full, then drain.
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, 5'd10, 32'hA0 + 32'(i), 1'b1, 5'(i), 32'h100 + 32'(i));
        cyc(1'b1, 5'd10, 32'hA5, 1'b1, 5'd5, 32'h105);
        check("full_ready", 32'(s_ready), 32'd0);
        check("full_count", 32'(s_count), 32'd4);
        check("full_pend", pend, 32'h1E);
        for (int i = 1; i <= 4; i++) begin
            idle();
            check("drain_WE", 32'(WE), 32'd1);
            check("drain_rW", 32'(rW), 32'(i));
            check("drain_W", W, 32'h100 + 32'(i));
            if (i == 1) check("pop_frees_ready", 32'(s_ready), 32'd1);
        end
        check("drain_count", 32'(s_count), 32'd0);

        // Kill: queued r7 write overtaken by a primary r7 write.
        cyc(1'b1, 5'd20, 32'h20, 1'b1, 5'd7, 32'h11);
        check("kill_pend_before", pend, 32'h80);
        cyc(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
        check("kill_pend_after", pend, 32'd0);
        check("kill_prim_W", W, 32'h22);
        check("kill_count", 32'(s_count), 32'd1);
        idle();
        check("kill_pop_WE", 32'(WE), 32'd0);
        check("kill_pop_count", 32'(s_count), 32'd0);

        // Simultaneous primary and secondary to r3.
        cyc(1'b1, 5'd3, 32'hAAA, 1'b1, 5'd3, 32'hBBB);
        check("simul_prim_W", W, 32'hAAA);
        check("simul_pend", pend, 32'h8);
        idle();
        check("simul_sec_WE", 32'(WE), 32'd1);
        check("simul_sec_rW", 32'(rW), 32'd3);
        check("simul_sec_W", W, 32'hBBB);

        // Secondary latency from an empty FIFO with idle primary.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h5);
`ifdef WB_BYPASS_EN
        check("byp_WE", 32'(WE), 32'd1);
        check("byp_rW", 32'(rW), 32'd9);
        check("byp_count", 32'(s_count), 32'd0);
        check("byp_pend", pend, 32'd0);
        idle();
`else
        check("lat_WE0", 32'(WE), 32'd0);
        check("lat_count", 32'(s_count), 32'd1);
        check("lat_pend", pend, 32'h200);
        idle();
        check("lat_WE1", 32'(WE), 32'd1);
        check("lat_rW", 32'(rW), 32'd9);
        check("lat_W", W, 32'h5);
`endif

        // Secondary to r0: handshake completes, nothing is queued or written.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
        check("sec_r0_count", 32'(s_count), 32'd0);
        check("sec_r0_WE", 32'(WE), 32'd0);

        // Mixed traffic pattern, checked by the model each cycle.
        for (int i = 0; i < 48; i++)
            cyc(1'b1 && ((i % 4) != 3), 5'((i * 3) % 8), 32'h1000 + 32'(i),
                (i % 3) != 1, 5'((i * 5 + 1) % 8), 32'h2000 + 32'(i));
        for (int i = 0; i < 3; i++) idle();

        // Async reset mid-cycle with three queued entries.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 5'd12, 32'hC0, 1'b1, 5'(4 + i), 32'h300 + 32'(i));
        check("pre_rst_count", 32'(s_count), 32'd3);
        p_we = 1'b0; s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_WE", 32'(WE), 32'd0);
        check("mid_rst_count", 32'(s_count), 32'd0);
        check("mid_rst_pend", pend, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) idle();
        check("post_rst_WE", 32'(WE), 32'd0);

        check("r7_stale_writes", 32'(r7_stale), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
